// File: rtl/alu_sequencer_pkg.sv
// alu_sequencer_pkg: ALU opcodes, sequencer states and the branch-resolve helper
package alu_sequencer_pkg;

   localparam int MUL_ITERS_DEF = 8;

   typedef enum logic [3:0] {
      kADD = 4'h0, kSUB = 4'h1, kSHL = 4'h2, kSHR = 4'h3,
      kAND = 4'h4, kXOR = 4'h5, kNOT = 4'h6, kLDR = 4'h7,
      kMLD = 4'h8, kLDI = 4'h9, kSTR = 4'hA, kMST = 4'hB,
      kCLR = 4'hC, kJMP = 4'hD, kBRZ = 4'hE, kBRN = 4'hF
   } op_mne_t;

   typedef enum logic [2:0] {IDLE, EXEC, MUL_ADD, MUL_SHF, FIN} seq_state_t;

   function automatic logic is_taken(op_mne_t op, logic z, logic neg);
      return (op == kJMP) || (op == kBRZ && z) || (op == kBRN && neg);
   endfunction

endpackage

// File: rtl/alu_sequencer.sv
// alu_sequencer: owns acc/flags, sequences the ALU per request incl. shift-add multiply; option ALU_SEQ_MUL_EARLY_EXIT_EN ends multiply once the multiplier is exhausted
module alu_sequencer
   import alu_sequencer_pkg::*;
#(
   parameter int W         = 8,
   parameter int MUL_ITERS = MUL_ITERS_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_req_valid,
   output logic         o_req_ready,
   input  logic [3:0]   i_req_op,
   input  logic         i_req_mul,
   input  logic [W-1:0] i_req_operand,
   input  logic         i_req_use_carry,
   output logic [3:0]   o_alu_op,
   output logic         o_alu_ci,
   output logic [W-1:0] o_alu_in_a,
   output logic [W-1:0] o_alu_in_acc,
   input  logic [W-1:0] i_alu_res,
   input  logic         i_alu_co,
   output logic [W-1:0] o_acc_q,
   output logic         o_co_q,
   output logic         o_z_q,
   output logic         o_neg_q,
   output logic         o_branch_taken,
   output logic         o_done,
   output logic         o_busy
);

   localparam int             CW   = $clog2(MUL_ITERS + 1);
   localparam logic [CW-1:0]  LAST = CW'(MUL_ITERS - 1);

   seq_state_t     r_state, w_next;
   op_mne_t        r_op, w_alu_op;
   logic [W-1:0]   r_opd, r_acc, r_p, r_m, r_q;
   logic           r_uc, r_co, r_z, r_neg, r_taken;
   logic [CW-1:0]  r_cnt;
   logic           w_mul_fin, w_z;

   // next state and ALU drive; idle drive is a side-effect-free STR of acc
   always_comb begin
      w_next       = r_state;
      w_alu_op     = kSTR;
      o_alu_ci     = 1'b0;
      o_alu_in_a   = '0;
      o_alu_in_acc = r_acc;
      case (r_state)
         IDLE:    w_next = i_req_valid ? (i_req_mul ? MUL_ADD : EXEC) : IDLE;
         EXEC: begin
            w_alu_op   = r_op;
            o_alu_in_a = r_opd;
            o_alu_ci   = (r_op == kADD && r_uc) ? r_co : 1'b0;
            w_next     = FIN;
         end
         MUL_ADD: begin
            w_alu_op     = kADD;
            o_alu_in_acc = r_p;
            o_alu_in_a   = r_m;
`ifdef ALU_SEQ_MUL_EARLY_EXIT_EN
            w_next       = (r_q == '0) ? FIN : MUL_SHF;
`else
            w_next       = MUL_SHF;
`endif
         end
         MUL_SHF: begin
            w_alu_op     = kSHL;
            o_alu_in_acc = r_m;
            o_alu_in_a   = W'(1);
            w_next       = (r_cnt == LAST) ? FIN : MUL_ADD;
         end
         FIN:     w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   assign o_alu_op  = w_alu_op;
   assign w_mul_fin = (r_state == MUL_ADD || r_state == MUL_SHF) && w_next == FIN;
   assign w_z       = (i_alu_res == '0);

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   // request latch and multiply working registers (P product, M shifted multiplicand, Q multiplier)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op  <= kADD;
         r_opd <= '0;
         r_uc  <= 1'b0;
         r_p   <= '0;
         r_m   <= '0;
         r_q   <= '0;
         r_cnt <= '0;
      end else begin
         case (r_state)
            IDLE: if (i_req_valid) begin
               r_op  <= op_mne_t'(i_req_op);
               r_opd <= i_req_operand;
               r_uc  <= i_req_use_carry;
               if (i_req_mul) begin
                  r_p   <= '0;
                  r_m   <= r_acc;
                  r_q   <= i_req_operand;
                  r_cnt <= '0;
               end
            end
            MUL_ADD: if (r_q[0]) r_p <= i_alu_res;
            MUL_SHF: begin
               r_m   <= i_alu_res;
               r_q   <= r_q >> 1;
               r_cnt <= r_cnt + CW'(1);
            end
            default: ;
         endcase
      end
   end

   // architectural commit: single-op results at end of EXEC, product at end of multiply
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc   <= '0;
         r_co    <= 1'b0;
         r_z     <= 1'b0;
         r_neg   <= 1'b0;
         r_taken <= 1'b0;
      end else if (r_state == EXEC) begin
         r_taken <= is_taken(r_op, r_z, r_neg);
         case (r_op)
            kADD, kSUB: begin
               r_acc <= i_alu_res;
               r_co  <= i_alu_co;
               r_z   <= w_z;
               r_neg <= i_alu_res[W-1];
            end
            kSHL: begin
               r_acc <= i_alu_res;
               r_co  <= i_alu_co;
               r_z   <= w_z;
            end
            kSHR, kAND, kXOR, kNOT, kLDR, kMLD, kLDI: begin
               r_acc <= i_alu_res;
               r_z   <= w_z;
            end
            kCLR: begin
               r_acc <= '0;
               r_co  <= 1'b0;
               r_z   <= 1'b0;
               r_neg <= 1'b0;
            end
            default: ;
         endcase
      end else if (w_mul_fin) begin
         r_acc   <= r_p;
         r_co    <= 1'b0;
         r_z     <= (r_p == '0);
         r_neg   <= r_p[W-1];
         r_taken <= 1'b0;
      end
   end

   assign o_acc_q        = r_acc;
   assign o_co_q         = r_co;
   assign o_z_q          = r_z;
   assign o_neg_q        = r_neg;
   assign o_done         = (r_state == FIN);
   assign o_branch_taken = o_done & r_taken;
   assign o_busy         = (r_state != IDLE);
   assign o_req_ready    = (r_state == IDLE);

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed bench with behavioural ALU, abstract architectural model and literal pins
module tb_alu_sequencer;
   import alu_sequencer_pkg::*;

   localparam int W = 8;
`ifdef ALU_SEQ_MUL_EARLY_EXIT_EN
   localparam int L_MUL7 = 8, L_MUL0 = 2;
`else
   localparam int L_MUL7 = 17, L_MUL0 = 17;
`endif

   logic         clk = 1'b0, rst_n = 1'b0;
   logic         req_valid = 1'b0, req_mul = 1'b0, req_uc = 1'b0;
   logic [3:0]   req_op = 4'h0;
   logic [W-1:0] req_opd = '0;
   logic         req_ready, alu_ci, alu_co, co_q, z_q, neg_q, branch_taken, done, busy;
   logic [3:0]   alu_op;
   logic [W-1:0] alu_in_a, alu_in_acc, alu_res, acc_q;
   logic [W:0]   t;

   always #5 clk = ~clk;

   alu_sequencer #(.W(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_op(req_op),
      .i_req_mul(req_mul), .i_req_operand(req_opd), .i_req_use_carry(req_uc),
      .o_alu_op(alu_op), .o_alu_ci(alu_ci), .o_alu_in_a(alu_in_a), .o_alu_in_acc(alu_in_acc),
      .i_alu_res(alu_res), .i_alu_co(alu_co),
      .o_acc_q(acc_q), .o_co_q(co_q), .o_z_q(z_q), .o_neg_q(neg_q),
      .o_branch_taken(branch_taken), .o_done(done), .o_busy(busy)
   );

   // behavioural 8-bit accumulator ALU; SUB carry is borrow, SHL/SHR shift acc by one
   always_comb begin
      t = {1'b0, alu_in_acc};
      case (op_mne_t'(alu_op))
         kADD: t = {1'b0, alu_in_acc} + {1'b0, alu_in_a} + {{W{1'b0}}, alu_ci};
         kSUB: t = {1'b0, alu_in_acc} - {1'b0, alu_in_a};
         kSHL: t = {alu_in_acc, 1'b0};
         kSHR: t = {alu_in_acc[0], 1'b0, alu_in_acc[W-1:1]};
         kAND: t = {1'b0, alu_in_acc & alu_in_a};
         kXOR: t = {1'b0, alu_in_acc ^ alu_in_a};
         kNOT: t = {1'b0, ~alu_in_acc};
         kLDR, kMLD, kLDI: t = {1'b0, alu_in_a};
         kCLR: t = '0;
         default: ;
      endcase
   end
   assign alu_res = t[W-1:0];
   assign alu_co  = t[W];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] o_acc = 0, n_acc = 0;
   logic       o_co = 0, o_z = 0, o_neg = 0, n_co = 0, n_z = 0, n_neg = 0, n_br = 0;
   int         acc_edge = 1 << 30, done_at = -1, m_lat = 0, last_lat = 0;
   int         n_cmp = 0, n_bad = 0;
   bit         chk = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // per-cycle comparison of every architectural/handshake output against the model
   task automatic check_cycle();
      logic busy_e, done_e;
      logic [7:0] a;
      logic c, z, n;
      busy_e = (cyc >= acc_edge) && (cyc <= done_at);
      done_e = (cyc == done_at);
      a = (cyc >= done_at) ? n_acc : o_acc;
      c = (cyc >= done_at) ? n_co  : o_co;
      z = (cyc >= done_at) ? n_z   : o_z;
      n = (cyc >= done_at) ? n_neg : o_neg;
      check("cycle{done,br,rdy,busy,acc,co,z,neg}",
            32'({done, branch_taken, req_ready, busy, acc_q, co_q, z_q, neg_q}),
            32'({done_e, done_e & n_br, !busy_e, busy_e, a, c, z, n}));
   endtask

   task automatic tick();
      @(negedge clk);
      if (chk) check_cycle();
   endtask

   function automatic int mul_lat(input logic [7:0] q);
`ifdef ALU_SEQ_MUL_EARLY_EXIT_EN
      int h;
      if (q == 0) return 2;
      h = 0;
      for (int i = 0; i < W; i++) if (q[i]) h = i;
      return (h == W - 1) ? 2 * W + 1 : 2 * h + 4;
`else
      return (q === 8'hxx) ? 0 : 2 * W + 1;
`endif
   endfunction

   // abstract architectural effect of one accepted request
   task automatic model_accept(input op_mne_t op, input logic mul, input logic [7:0] opd, input logic uc, input int c);
      int s;
      logic [15:0] prod;
      o_acc = n_acc; o_co = n_co; o_z = n_z; o_neg = n_neg;
      n_br = 0;
      if (mul) begin
         prod = 16'(o_acc) * 16'(opd);
         n_acc = prod[7:0]; n_co = 0; n_z = (n_acc == 0); n_neg = n_acc[7];
         m_lat = mul_lat(opd);
      end else begin
         m_lat = 2;
         case (op)
            kADD: begin
               s = int'(o_acc) + int'(opd) + int'(uc & o_co);
               n_acc = s[7:0]; n_co = (s > 255); n_z = (n_acc == 0); n_neg = n_acc[7];
            end
            kSUB: begin
               n_acc = o_acc - opd; n_co = (o_acc < opd); n_z = (n_acc == 0); n_neg = n_acc[7];
            end
            kSHL: begin
               s = int'(o_acc) * 2;
               n_acc = s[7:0]; n_co = (o_acc >= 128); n_z = (n_acc == 0);
            end
            kSHR: begin n_acc = o_acc / 2; n_z = (n_acc == 0); end
            kAND: begin n_acc = o_acc & opd; n_z = (n_acc == 0); end
            kXOR: begin n_acc = o_acc ^ opd; n_z = (n_acc == 0); end
            kNOT: begin n_acc = ~o_acc; n_z = (n_acc == 0); end
            kLDR, kMLD, kLDI: begin n_acc = opd; n_z = (n_acc == 0); end
            kCLR: begin n_acc = 0; n_co = 0; n_z = 0; n_neg = 0; end
            kJMP: n_br = 1;
            kBRZ: n_br = o_z;
            kBRN: n_br = o_neg;
            default: ;
         endcase
      end
      acc_edge = c + 1;
      done_at  = c + m_lat;
   endtask

   // present a request and hold it until accepted
   task automatic issue(input op_mne_t op, input logic mul, input logic [7:0] opd, input logic uc);
      bit ok;
      ok = 0;
      req_op = op; req_mul = mul; req_opd = opd; req_uc = uc; req_valid = 1;
      for (int k = 0; k < 60; k++) begin
         if (req_ready) begin
            ok = 1;
            break;
         end
         tick();
      end
      if (!ok) check("accept_timeout", 0, 1);
      else model_accept(op, mul, opd, uc, cyc);
      tick();
      req_valid = 0;
   endtask

   task automatic wait_done();
      bit ok;
      ok = 0;
      for (int k = 0; k < 60; k++) begin
         if (done) begin
            ok = 1;
            last_lat = cyc - acc_edge + 1;
            break;
         end
         tick();
      end
      if (!ok) check("done_timeout", 0, 1);
      else check("latency", last_lat, m_lat);
   endtask

   task automatic run(input op_mne_t op, input logic mul, input logic [7:0] opd, input logic uc);
      issue(op, mul, opd, uc);
      wait_done();
   endtask

   typedef struct packed {
      op_mne_t    op;
      logic [7:0] opd;
      logic       uc;
      logic [7:0] acc;
      logic       co, z, neg, br;
   } vec_t;

   vec_t vt [18];
   int   d1;

   initial begin
      vt[0]  = '{kLDI, 8'hA5, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[1]  = '{kSUB, 8'h06, 1'b0, 8'h9F, 1'b0, 1'b0, 1'b1, 1'b0};
      vt[2]  = '{kSHL, 8'h00, 1'b0, 8'h3E, 1'b1, 1'b0, 1'b1, 1'b0};
      vt[3]  = '{kSHR, 8'h00, 1'b0, 8'h1F, 1'b1, 1'b0, 1'b1, 1'b0};
      vt[4]  = '{kAND, 8'h0F, 1'b0, 8'h0F, 1'b1, 1'b0, 1'b1, 1'b0};
      vt[5]  = '{kBRZ, 8'h00, 1'b0, 8'h0F, 1'b1, 1'b0, 1'b1, 1'b0};
      vt[6]  = '{kXOR, 8'h0F, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
      vt[7]  = '{kNOT, 8'h00, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0};
      vt[8]  = '{kBRN, 8'h00, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1};
      vt[9]  = '{kSTR, 8'h55, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0};
      vt[10] = '{kMST, 8'hAA, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0};
      vt[11] = '{kLDR, 8'h3C, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0};
      vt[12] = '{kMLD, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
      vt[13] = '{kJMP, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1};
      vt[14] = '{kBRZ, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1};
      vt[15] = '{kSUB, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0};
      vt[16] = '{kADD, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0};
      vt[17] = '{kADD, 8'h00, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};

      repeat (2) @(negedge clk);
      rst_n = 1;
      chk = 1;
      tick();
      check("reset_state", 32'({req_ready, busy, done, branch_taken, acc_q, co_q, z_q, neg_q}), 32'({4'b1000, 8'h00, 3'b000}));

      run(kLDI, 0, 8'h7F, 0);
      run(kADD, 0, 8'h01, 0);
      check("add_lat", last_lat, 2);
      check("add_7f_01", 32'({acc_q, co_q, z_q, neg_q}), 32'({8'h80, 3'b001}));

      run(kLDI, 0, 8'hFF, 0);
      run(kADD, 0, 8'h01, 0);
      check("add_ff_01", 32'({acc_q, co_q, z_q, neg_q}), 32'({8'h00, 3'b110}));
      run(kADD, 0, 8'h00, 1);
      check("adc_carry_in", 32'({acc_q, co_q, z_q, neg_q}), 32'({8'h01, 3'b000}));

      run(kLDI, 0, 8'h06, 0);
      run(kADD, 1, 8'h07, 0);
      check("mul_6x7", 32'({acc_q, co_q, z_q, neg_q}), 32'({8'h2A, 3'b000}));
      check("mul_6x7_lat", last_lat, L_MUL7);
      run(kADD, 1, 8'h00, 0);
      check("mul_x0", 32'({acc_q, co_q, z_q, neg_q}), 32'({8'h00, 3'b010}));
      check("mul_x0_lat", last_lat, L_MUL0);
      run(kLDI, 0, 8'h03, 0);
      run(kADD, 1, 8'h81, 0);
      check("mul_3x81_wrap", 32'({acc_q, co_q, z_q, neg_q}), 32'({8'h83, 3'b001}));
      check("mul_3x81_lat", last_lat, 17);

      run(kCLR, 0, 8'h00, 0);
      check("clr", 32'({acc_q, co_q, z_q, neg_q}), 32'({8'h00, 3'b000}));
      run(kLDI, 0, 8'h00, 0);
      run(kBRZ, 0, 8'h00, 0);
      check("brz_taken", 32'({branch_taken, acc_q, co_q, z_q, neg_q}), 32'({1'b1, 8'h00, 3'b010}));
      run(kBRN, 0, 8'h00, 0);
      check("brn_not_taken", 32'({branch_taken, acc_q, co_q, z_q, neg_q}), 32'({1'b0, 8'h00, 3'b010}));

      for (int i = 0; i < 18; i++) begin
         run(vt[i].op, 0, vt[i].opd, vt[i].uc);
         check($sformatf("vec%0d", i), 32'({branch_taken, acc_q, co_q, z_q, neg_q}),
               32'({vt[i].br, vt[i].acc, vt[i].co, vt[i].z, vt[i].neg}));
      end

      run(kLDI, 0, 8'h06, 0);
      issue(kADD, 1, 8'h07, 0);
      d1 = done_at;
      issue(kLDI, 0, 8'h11, 0);
      check("held_accept_after_fin", acc_edge - d1, 2);
      wait_done();
      check("held_result", 32'(acc_q), 32'h11);

      issue(kADD, 1, 8'h07, 0);
      repeat (3) tick();
      #2 rst_n = 0;
      chk = 0;
      #1 check("async_reset", 32'({acc_q, co_q, z_q, neg_q, done, branch_taken, busy, req_ready}), 32'({8'h00, 7'b0000001}));
      o_acc = 0; n_acc = 0; o_co = 0; n_co = 0; o_z = 0; n_z = 0; o_neg = 0; n_neg = 0; n_br = 0;
      acc_edge = 1 << 30;
      done_at = -1;
      repeat (2) @(negedge clk);
      rst_n = 1;
      chk = 1;
      tick();
      check("ready_after_reset", 32'({req_ready, busy}), 32'b10);
      run(kLDI, 0, 8'h03, 0);
      run(kADD, 0, 8'h04, 0);
      check("alive_after_reset", 32'({acc_q, co_q, z_q, neg_q}), 32'({8'h07, 3'b000}));
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Controller that owns the architectural accumulator and flag registers and sequences the existing 8-bit accumulator ALU (4-bit opcode from the definitions package). It accepts one operation at a time over a valid/ready handshake, drives the ALU combinational inputs, captures results and flags, and resolves branch conditions. It also runs an 8x8 multiply (low byte) as a multi-cycle shift-add sequence of ALU ADD/SHL steps. It sits between instruction decode and the ALU in the core top level.

Parameters:
W, 8, datapath width (acc, operands)
MUL_ITERS, 8, shift-add iterations for multiply (= W)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  high only in IDLE
req_op  in  4  ALU opcode (definitions enum); ignored when req_mul=1
req_mul  in  1  request is multiply: acc <= acc * req_operand
req_operand  in  W  operand / immediate / memory data
req_use_carry  in  1  ADD uses co_q as carry-in
alu_op  out  4  to ALU op
alu_ci  out  1  to ALU ci
alu_in_a  out  W  to ALU in_a
alu_in_acc  out  W  to ALU in_acc
alu_res  in  W  from ALU acc
alu_co  in  1  from ALU co
acc_q  out  W  architectural accumulator
co_q, z_q, neg_q  out  1 each  architectural flags
branch_taken  out  1  1-cycle pulse with done for taken JMP/BRN/BRZ
done  out  1  1-cycle pulse: result/flags visible this cycle
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE; acc_q, co_q, z_q, neg_q, done, branch_taken = 0; internal P/M/Q/count = 0; aborts any operation in flight immediately.
- States: IDLE, EXEC, MUL_ADD, MUL_SHF, FIN.
- IDLE: req_ready=1. Accept on req_valid&req_ready at clock edge; latch op, operand, use_carry, mul. Goto MUL_ADD if mul (P=0, M=acc_q, Q=operand, count=0) else EXEC.
- EXEC (1 cycle): alu_op=latched op, alu_in_acc=acc_q, alu_in_a=operand, alu_ci = (op==kADD && use_carry) ? co_q : 0. At end of cycle, commit per op, goto FIN.
- Commit rules (result r=alu_res):
  kADD/kSUB: acc_q<=r, co_q<=alu_co, z_q<=(r==0), neg_q<=r[W-1].
  kSHL: acc_q<=r, co_q<=alu_co, z_q<=(r==0); neg unchanged.
  kSHR/kAND/kXOR/kNOT/kLDR/kMLD/kLDI: acc_q<=r, z_q<=(r==0); co, neg unchanged.
  kSTR/kMST: no register change.
  kCLR: acc_q, co_q, z_q, neg_q <= 0.
  kJMP: taken; kBRZ: taken iff z_q; kBRN: taken iff neg_q; no register change.
- Flags derive only from alu_res/alu_co; ALU z/neg outputs are unused.
- MUL_ADD: if Q[0]: alu_op=kADD, in_acc=P, in_a=M, ci=0, P<=alu_res; else no P write (alu_op=kADD still driven). Goto MUL_SHF.
- MUL_SHF: alu_op=kSHL, in_acc=M, in_a=1, M<=alu_res; Q<=Q>>1; count++. If count==MUL_ITERS-1 goto FIN-commit, else MUL_ADD. Overflow past W bits discarded.
- Multiply commit: acc_q<=P, co_q<=0, z_q<=(P==0), neg_q<=P[W-1].
- FIN (1 cycle): done=1, branch_taken per branch result, busy=1, req_ready=0; goto IDLE.
- Latency: non-mul op accept->done = 2 cycles (EXEC, FIN); throughput 1 op / 3 cycles. Multiply: 2*MUL_ITERS + 1 cycles after accept.
- req_valid while busy: ignored (no queueing); requester holds until ready.
- Idle ALU drive: alu_op=kSTR, inputs = acc_q, 0, ci=0 (no side effects).

Optional Feature:
ALU_SEQ_MUL_EARLY_EXIT_EN: when defined, entering MUL_ADD with Q==0 goes straight to commit+FIN (multiply by 0 = 1 cycle + FIN; iterations = index of highest set bit + 1). When undefined, always MUL_ITERS iterations; results identical, only latency differs.

Decomposition:
- definitions package: seq_state_t enum (IDLE, EXEC, MUL_ADD, MUL_SHF, FIN); localparam MUL_ITERS default; reuse existing op_mne/opcode constants.
- No sub-module; ALU is instantiated beside this block by the parent (and by the bench).

Test Plan:
- Reset, LDI 0x7F, ADD 0x01 -> acc_q=0x80, neg_q=1, co_q=0, z_q=0; done exactly 2 cycles after accept.
- LDI 0xFF, ADD 0x01 then ADD 0x00 with req_use_carry=1 -> 0x00/co=1/z=1, then 0x01/co=0.
- acc=0x06, mul 0x07 -> acc_q=0x2A, co=0, z=0; done 17 cycles after accept (EN off); mul 0x00 -> z=1, done 2 cycles (EN on).
- acc=0x00 after CLR, BRZ -> branch_taken=1 with done; BRN -> branch_taken=0; acc/flags unchanged.
- req_valid held during multiply -> req_ready=0, second request accepted only the cycle after FIN.
- rst_n low mid-multiply (cycle 5) -> all outputs 0 asynchronously, IDLE, req_ready=1 after release.
